// File: rtl/z80_bus_arbiter.sv
// Round-robin BUSRQ/BUSAK arbiter sharing the Z80 external bus
// between the CPU and up to eight external bus masters.
module z80_bus_arbiter #(
    parameter  int N_REQ    = 2,
    parameter  int MAX_HOLD = 256,
    parameter  int CPU_GAP  = 4,
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] owner,
    output logic             busrq_n,
    input  logic             busak_n,
    output logic             bus_float,
    output logic             busy,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int GAP_W  = (CPU_GAP > 0) ? $clog2(CPU_GAP + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(CPU_GAP);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        GRANT,
        RELEASE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  pick;
    logic              any_req;
    logic              owner_req;
    logic [GAP_W-1:0]  gap_q;
    logic [HOLD_W-1:0] hold_q;

    // Search starts just after the last granted index and wraps mod N_REQ.
    always_comb begin
        win     = last_q;
        pick    = last_q;
        any_req = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            pick = IDX_W'((int'(last_q) + i) % N_REQ);
            if (!any_req && req[pick]) begin
                win     = pick;
                any_req = 1'b1;
            end
        end
    end

    assign owner_req = req[owner];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busrq_n   <= 1'b1;
            gnt       <= '0;
            bus_float <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            owner     <= '0;
            last_q    <= IDX_LAST;
            gap_q     <= GAP_MAX;
            hold_q    <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gap_q != GAP_MAX) begin
                        gap_q <= gap_q + 1'b1;
                    end else if (any_req) begin
                        owner   <= win;
                        state   <= REQUEST;
                        busrq_n <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (!owner_req) begin
                        state   <= RELEASE;
                        busrq_n <= 1'b1;
                    end else if (!busak_n) begin
                        state     <= GRANT;
                        gnt       <= N_REQ'(1) << owner;
                        bus_float <= 1'b1;
                        last_q    <= owner;
                        hold_q    <= '0;
                    end
                end
                GRANT: begin
                    hold_q <= hold_q + 1'b1;
                    if (!owner_req ||
                        (MAX_HOLD != 0 && hold_q == HOLD_LAST)) begin
                        state   <= RELEASE;
                        gnt     <= '0;
                        busrq_n <= 1'b1;
                        // A simultaneous drop counts as a normal release.
                        timeout <= owner_req;
                    end
                end
                RELEASE: begin
                    if (busak_n) begin
                        state     <= IDLE;
                        bus_float <= 1'b0;
                        busy      <= 1'b0;
                        gap_q     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter with a simple Z80 BUSAK model
// (BUSAK falls 3 cycles after BUSRQ falls, rises as soon as BUSRQ rises).
module tb_z80_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Instance A: N_REQ=2, MAX_HOLD=256, CPU_GAP=4
    logic [1:0] req_a = '0, gnt_a;
    logic [0:0] own_a;
    logic busrq_a, busak_a = 1'b1, flt_a, busy_a, to_a;
    logic en_a = 1'b1;
    int ca = 0;

    // Instance T: N_REQ=2, MAX_HOLD=8, CPU_GAP=4
    logic [1:0] req_t = '0, gnt_t;
    logic [0:0] own_t;
    logic busrq_t, busak_t = 1'b1, flt_t, busy_t, to_t;
    int ct = 0;

    // Instance B: N_REQ=3, MAX_HOLD=0 (unlimited), CPU_GAP=0
    logic [2:0] req_b = '0, gnt_b;
    logic [1:0] own_b;
    logic busrq_b, busak_b = 1'b1, flt_b, busy_b, to_b;
    int cb = 0;

    z80_bus_arbiter #(.N_REQ(2), .MAX_HOLD(256), .CPU_GAP(4)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .gnt(gnt_a), .owner(own_a),
        .busrq_n(busrq_a), .busak_n(busak_a), .bus_float(flt_a),
        .busy(busy_a), .timeout(to_a));

    z80_bus_arbiter #(.N_REQ(2), .MAX_HOLD(8), .CPU_GAP(4)) u_t (
        .clk(clk), .reset(reset), .req(req_t), .gnt(gnt_t), .owner(own_t),
        .busrq_n(busrq_t), .busak_n(busak_t), .bus_float(flt_t),
        .busy(busy_t), .timeout(to_t));

    z80_bus_arbiter #(.N_REQ(3), .MAX_HOLD(0), .CPU_GAP(0)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .gnt(gnt_b), .owner(own_b),
        .busrq_n(busrq_b), .busak_n(busak_b), .bus_float(flt_b),
        .busy(busy_b), .timeout(to_b));

    always @(negedge clk) begin
        if (!busrq_a && en_a) begin
            ca = ca + 1;
            if (ca >= 3) busak_a = 1'b0;
        end else begin
            ca = 0;
            busak_a = 1'b1;
        end
        if (!busrq_t) begin
            ct = ct + 1;
            if (ct >= 3) busak_t = 1'b0;
        end else begin
            ct = 0;
            busak_t = 1'b1;
        end
        if (!busrq_b) begin
            cb = cb + 1;
            if (cb >= 3) busak_b = 1'b0;
        end else begin
            cb = 0;
            busak_b = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_a = '0;
        req_t = '0;
        req_b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_chk++; if (busrq_a !== 1'b1) begin n_fail++; $display("FAIL rst_busrq got %b want 1", busrq_a); end
        n_chk++; if (gnt_a !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got %b want 00", gnt_a); end
        n_chk++; if (flt_a !== 1'b0) begin n_fail++; $display("FAIL rst_float got %b want 0", flt_a); end
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_a); end
        n_chk++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b want 0", to_a); end
        n_chk++; if (own_a !== 1'b0) begin n_fail++; $display("FAIL rst_owner got %b want 0", own_a); end
        n_chk++; if (own_b !== 2'd0) begin n_fail++; $display("FAIL rst_owner_b got %0d want 0", own_b); end
    endtask

    task automatic test_single();
        req_a = 2'b01;
        step();
        n_chk++; if (busrq_a !== 1'b0) begin n_fail++; $display("FAIL single_busrq got %b want 0", busrq_a); end
        n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy_a); end
        n_chk++; if (own_a !== 1'b0) begin n_fail++; $display("FAIL single_owner got %b want 0", own_a); end
        repeat (2) step();
        n_chk++; if (gnt_a !== 2'b00) begin n_fail++; $display("FAIL single_early_gnt got %b want 00", gnt_a); end
        step();
        n_chk++; if (gnt_a !== 2'b01) begin n_fail++; $display("FAIL single_gnt got %b want 01", gnt_a); end
        n_chk++; if (flt_a !== 1'b1) begin n_fail++; $display("FAIL single_float got %b want 1", flt_a); end
        repeat (2) step();
        req_a = 2'b00;
        step();
        n_chk++; if (gnt_a !== 2'b00) begin n_fail++; $display("FAIL single_drop_gnt got %b want 00", gnt_a); end
        n_chk++; if (busrq_a !== 1'b1) begin n_fail++; $display("FAIL single_drop_busrq got %b want 1", busrq_a); end
        n_chk++; if (flt_a !== 1'b1) begin n_fail++; $display("FAIL single_rel_float got %b want 1", flt_a); end
        step();
        n_chk++; if (flt_a !== 1'b0) begin n_fail++; $display("FAIL single_idle_float got %b want 0", flt_a); end
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", busy_a); end
    endtask

    task automatic test_round_robin();
        int idle;
        bit got;
        logic [1:0] want;
        do_reset();
        req_a = 2'b11;
        for (int g = 0; g < 4; g++) begin
            want = 2'(1 << (g % 2));
            idle = 0;
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                step();
                if (!busy_a) idle++;
                if (gnt_a != 2'b00) got = 1'b1;
            end
            n_chk++; if (!got) begin n_fail++; $display("FAIL rr_wait%0d got no grant want %b", g, want); end
            n_chk++; if (gnt_a !== want) begin n_fail++; $display("FAIL rr_gnt%0d got %b want %b", g, gnt_a, want); end
            if (g > 0) begin
                n_chk++; if (idle < 4) begin n_fail++; $display("FAIL rr_gap%0d got %0d idle want >=4", g, idle); end
            end
            repeat (9) @(posedge clk);
            #1;
            n_chk++; if (gnt_a !== want) begin n_fail++; $display("FAIL rr_hold%0d got %b want %b", g, gnt_a, want); end
            req_a = req_a & ~want;
            step();
            n_chk++; if (gnt_a !== 2'b00) begin n_fail++; $display("FAIL rr_rel%0d got %b want 00", g, gnt_a); end
            req_a = 2'b11;
        end
        req_a = 2'b00;
    endtask

    task automatic test_timeout();
        int hc;
        int pulses;
        bit got;
        bit done;
        do_reset();
        req_t = 2'b10;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (gnt_t != 2'b00) got = 1'b1;
        end
        n_chk++; if (gnt_t !== 2'b10) begin n_fail++; $display("FAIL to_first_gnt got %b want 10", gnt_t); end
        req_t = 2'b11;
        hc = 1;
        pulses = 0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            step();
            if (to_t) pulses++;
            if (gnt_t == 2'b10) hc++;
            else done = 1'b1;
        end
        n_chk++; if (hc !== 8) begin n_fail++; $display("FAIL to_len got %0d want 8", hc); end
        n_chk++; if (to_t !== 1'b1) begin n_fail++; $display("FAIL to_pulse got %b want 1", to_t); end
        step();
        if (to_t) pulses++;
        n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL to_pulse_cnt got %0d want 1", pulses); end
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (gnt_t != 2'b00) got = 1'b1;
        end
        n_chk++; if (gnt_t !== 2'b01) begin n_fail++; $display("FAIL to_next_gnt got %b want 01", gnt_t); end
        n_chk++; if (own_t !== 1'b0) begin n_fail++; $display("FAIL to_next_owner got %b want 0", own_t); end
        // drop coincides with the last allowed hold cycle
        repeat (7) @(posedge clk);
        #1;
        n_chk++; if (gnt_t !== 2'b01) begin n_fail++; $display("FAIL to_edge_hold got %b want 01", gnt_t); end
        req_t = 2'b10;
        step();
        n_chk++; if (gnt_t !== 2'b00) begin n_fail++; $display("FAIL to_edge_gnt got %b want 00", gnt_t); end
        n_chk++; if (to_t !== 1'b0) begin n_fail++; $display("FAIL to_edge_pulse got %b want 0", to_t); end
        req_t = 2'b00;
    endtask

    task automatic test_abort();
        bit seen;
        do_reset();
        en_a = 1'b0;
        seen = 1'b0;
        req_a = 2'b01;
        step();
        n_chk++; if (busrq_a !== 1'b0) begin n_fail++; $display("FAIL abort_busrq got %b want 0", busrq_a); end
        step();
        if (gnt_a != 2'b00) seen = 1'b1;
        req_a = 2'b00;
        step();
        if (gnt_a != 2'b00) seen = 1'b1;
        n_chk++; if (busrq_a !== 1'b1) begin n_fail++; $display("FAIL abort_rel_busrq got %b want 1", busrq_a); end
        n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_rel_busy got %b want 1", busy_a); end
        step();
        if (gnt_a != 2'b00) seen = 1'b1;
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy got %b want 0", busy_a); end
        n_chk++; if (flt_a !== 1'b0) begin n_fail++; $display("FAIL abort_float got %b want 0", flt_a); end
        n_chk++; if (seen) begin n_fail++; $display("FAIL abort_gnt got 1 want 0"); end
        en_a = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        bit got;
        do_reset();
        req_a = 2'b10;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (gnt_a != 2'b00) got = 1'b1;
        end
        n_chk++; if (gnt_a !== 2'b10) begin n_fail++; $display("FAIL mid_gnt got %b want 10", gnt_a); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_chk++; if (gnt_a !== 2'b00) begin n_fail++; $display("FAIL mid_rst_gnt got %b want 00", gnt_a); end
        n_chk++; if (busrq_a !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busrq got %b want 1", busrq_a); end
        n_chk++; if (flt_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_float got %b want 0", flt_a); end
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy_a); end
        n_chk++; if (own_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_owner got %b want 0", own_a); end
        req_a = 2'b11;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (gnt_a != 2'b00) got = 1'b1;
        end
        n_chk++; if (gnt_a !== 2'b01) begin n_fail++; $display("FAIL mid_next_gnt got %b want 01", gnt_a); end
        req_a = 2'b00;
        repeat (3) step();
    endtask

    task automatic test_wrap();
        int idle;
        bit got;
        logic [2:0] want;
        do_reset();
        req_b = 3'b111;
        for (int g = 0; g < 4; g++) begin
            want = 3'(1 << (g % 3));
            idle = 0;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                step();
                n_chk++; if (!$onehot0(gnt_b)) begin n_fail++; $display("FAIL wrap_onehot got %b want <=1 hot", gnt_b); end
                if (!busy_b) idle++;
                if (gnt_b != 3'b000) got = 1'b1;
            end
            n_chk++; if (gnt_b !== want) begin n_fail++; $display("FAIL wrap_gnt%0d got %b want %b", g, gnt_b, want); end
            if (g > 0) begin
                n_chk++; if (idle !== 1) begin n_fail++; $display("FAIL wrap_gap%0d got %0d want 1", g, idle); end
            end
            for (int c = 0; c < 4; c++) begin
                step();
                n_chk++; if (gnt_b !== want) begin n_fail++; $display("FAIL wrap_hold%0d got %b want %b", g, gnt_b, want); end
            end
            req_b = req_b & ~want;
            step();
            n_chk++; if (gnt_b !== 3'b000) begin n_fail++; $display("FAIL wrap_rel%0d got %b want 000", g, gnt_b); end
            req_b = 3'b111;
        end
        req_b = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_abort();
        test_reset_mid_grant();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_bus_arbiter.md
# z80_bus_arbiter

Shares the Z80 core's external address/data/control bus between the CPU and up to eight external bus masters (DMA engine, debug/loader port) by sequencing the Z80 BUSRQ/BUSAK handshake. It sits next to the `z80` wrapper, on the same clock. It drives the core's `busrq_n` input and watches its `busak_n` output. It grants the bus to one requester at a time, round-robin, and supplies a `bus_float` flag that the pad layer uses to tri-state the CPU's address, data, MREQ, IORQ, RD and WR pins while a master owns the bus.

## Interface
- `N_REQ`, 2: number of external requesters, 1..8.
- `MAX_HOLD`, 256: maximum grant length in cycles; 0 = unlimited.
- `CPU_GAP`, 4: minimum IDLE cycles after a release before a new BUSRQ is issued.
- `clk`  in  1: single clock, same as the Z80 core clock.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: level request per master; held high until the master is done.
- `gnt`  out  N_REQ: one-hot grant; at most one bit set.
- `owner`  out  IDX_W: index of the current or last granted master; IDX_W = max(1, clog2(N_REQ)).
- `busrq_n`  out  1: to Z80 `busrq_n`; active low.
- `busak_n`  in  1: from Z80 `busak_n`; same clock domain, no synchronizer.
- `bus_float`  out  1: 1 = CPU bus pins must be tri-stated (oeb=1).
- `busy`  out  1: state is not IDLE.
- `timeout`  out  1: one-cycle pulse when a grant is force-ended by MAX_HOLD.

## Operation
- All outputs are registered.
- FSM states: IDLE, REQUEST, GRANT, RELEASE.
- **IDLE**
  - Outputs: `busrq_n`=1, `gnt`=0, `bus_float`=0.
  - The gap counter counts up to CPU_GAP and then saturates.
  - If the gap is satisfied and `|req`:
    - Select the winner round-robin, searching from `last+1` mod N_REQ upward. `last` is the last granted index.
    - Latch the winner into `owner` and go to REQUEST.
- **REQUEST**
  - Outputs: `busrq_n`=0.
  - If `req[owner]`=0, go to RELEASE (abort).
  - Otherwise, if `busak_n`=0:
    - Go to GRANT.
    - Set `gnt[owner]` and `bus_float`.
    - Load `last`=`owner` and clear the hold counter.
- **GRANT**
  - Outputs: `busrq_n`=0, `gnt[owner]`=1, `bus_float`=1. The hold counter increments each cycle.
  - Exit to RELEASE when `req[owner]`=0.
  - Also exit to RELEASE when MAX_HOLD≠0 and the hold counter = MAX_HOLD−1. In that case pulse `timeout` on the transition.
  - In both cases `gnt` clears on entry to RELEASE.
- **RELEASE**
  - Outputs: `busrq_n`=1, `gnt`=0.
  - `bus_float` remains 1 while `busak_n`=0, so the master has stopped driving before the CPU resumes.
  - When `busak_n`=1, go to IDLE: clear `bus_float` and the gap counter.
- A force-ended master must drop and re-raise `req`. The round-robin rule prevents re-granting it while another master is pending.
- Requests that change while in REQUEST, GRANT or RELEASE are ignored, except `req[owner]`. Arbitration happens only in IDLE.
- Width rules:
  - Hold counter width is clog2(MAX_HOLD+1).
  - Gap counter width is clog2(CPU_GAP+1).
  - The round-robin index wraps modulo N_REQ. It is not a power-of-two wrap when N_REQ=3,5,6,7.

## Timing
- Reset values:
  - State = IDLE.
  - Outputs: `busrq_n`=1, `gnt`=0, `bus_float`=0, `busy`=0, `timeout`=0, `owner`=0.
  - Internal: `last`=N_REQ−1, so requester 0 wins first. Gap counter = CPU_GAP, so there is no gap after reset.
- `reset` mid-grant returns to reset values on the next edge without waiting for `busak_n`. The Z80 core is reset by the same system reset.
- `req` high in cycle t (IDLE, gap met) gives `busrq_n`=0 from t+1.
- `busak_n` low sampled at edge t gives `gnt` and `bus_float` high from t+1. Z80 BUSAK latency is not bounded by this block.
- `req[owner]` low at t gives `gnt`=0 and `busrq_n`=1 from t+1. `bus_float` falls one cycle after `busak_n` is sampled high.
- Simultaneous `req[owner]` drop and hold expiry counts as a normal release: no `timeout` pulse.
- With CPU_GAP=0, IDLE→REQUEST is allowed in the first IDLE cycle after RELEASE.
- Maximum grant with MAX_HOLD=M is exactly M cycles of `gnt` high.

## Test plan
- **Single request, N_REQ=2:** `req`=01 after reset; bench model asserts `busak_n` 3 cycles after `busrq_n` falls → `gnt`=01 one cycle after `busak_n`=0, `bus_float`=1, `owner`=0. Drop `req` → `gnt`=00 next cycle; `bus_float` clears one cycle after `busak_n` returns high.
- **Round-robin:** `req`=11 held continuously, each master drops after 10 grant cycles → grant order 0,1,0,1; each new BUSRQ issued no earlier than 4 IDLE cycles (CPU_GAP=4) after the prior release.
- **Timeout, MAX_HOLD=8:** `req[1]` held forever → `gnt[1]` high exactly 8 cycles, `timeout` pulses once; with `req[0]` also pending, the next grant goes to 0.
- **Abort in REQUEST:** `req[0]` drops before `busak_n` falls → no `gnt` ever asserted; `busrq_n` returns 1 next cycle; FSM goes through RELEASE to IDLE.
- **Reset mid-grant:** `reset` pulse while `gnt`=10 and `busak_n`=0 → next cycle all outputs at reset values; next `req`=11 grants requester 0 first.
- **N_REQ=3 wrap:** `req`=111 with 5-cycle holds → order 0,1,2,0; `gnt` is never multi-hot, checked every cycle.
